// File: rtl/pending_encoder_pkg.sv
// Shared sizing, FSM state type and one-hot helper for the pending request encoder.
package pending_encoder_pkg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] k);
        logic [N-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pending_encoder_if.sv
// Request/handshake bundle between the request sources/consumer (master) and the encoder (slave).
interface pending_encoder_if;
    import pending_encoder_pkg::*;

    logic [N-1:0] req;
    logic         en;
    logic         ack;
    logic [W-1:0] out;
    logic         valid;
    logic [N-1:0] pending;
    logic         lost;

    modport master (
        output req, en, ack,
        input  out, valid, pending, lost
    );

    modport slave (
        input  req, en, ack,
        output out, valid, pending, lost
    );

endinterface

// File: rtl/pending_encoder_prio_sel.sv
// Combinational find-first-set over N bits, searching upward from a start index with wrap.
module prio_sel
    import pending_encoder_pkg::*;
(
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   first;

    // Rotate so bit 'start' lands at position 0; the lowest set bit of rot is the winner.
    assign dbl = {vec, vec} >> start;
    assign rot = dbl[N-1:0];

    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = W'(i);
        end
    end

    assign idx = first + start;
    assign any = |vec;

endmodule

// File: rtl/pending_encoder.sv
// Sticky request register + N-to-W encoder with valid/ack handshake.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 0 highest).
module pending_encoder
    import pending_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    pending_encoder_if.slave  bus
);

    state_t       state;
    logic [N-1:0] pending;
    logic [W-1:0] out;
    logic         valid;
    logic         lost;
    logic [N-1:0] clr;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         sel_any;

    assign clr = (valid && bus.ack) ? onehot(out) : '0;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;

    // Next search begins just past the code that was accepted; W-bit add wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rr_ptr <= '0;
        else if (valid && bus.ack) rr_ptr <= out + W'(1);
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    prio_sel u_sel (
        .vec   (pending),
        .start (start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Set wins over clear, so a request re-raised during its own ack stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            lost    <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | bus.req;
            lost    <= |(bus.req & pending & ~clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en && sel_any) begin
                        out   <= sel_idx;
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out     = out;
    assign bus.valid   = valid;
    assign bus.pending = pending;
    assign bus.lost    = lost;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder; scoreboard of expected codes drained via valid/ack.
module tb_pending_encoder;
    import pending_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] rr = '0;
    logic [W-1:0] exp_q[$];

    pending_encoder_if bus();

    pending_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference selection: fixed mode always searches from 0.
    function automatic logic [W-1:0] model_sel(input logic [N-1:0] p, input logic [W-1:0] ptr);
        logic [W-1:0] k;
        logic [W-1:0] s;
`ifdef ROUND_ROBIN_EN
        s = ptr;
`else
        s = '0;
`endif
        for (int i = N - 1; i >= 0; i--) begin
            k = s + W'(i);
            if (p[k]) model_sel = k;
        end
        if (p == '0) model_sel = '0;
    endfunction

    task automatic push_served(input logic [N-1:0] p);
        logic [W-1:0] ptr;
        logic [W-1:0] k;
        ptr = rr;
        while (p != '0) begin
            k = model_sel(p, ptr);
            exp_q.push_back(k);
            p[k] = 1'b0;
            ptr  = k + W'(1);
        end
    endtask

    // Expects ack held high: each accepted code must be followed by one valid-low bubble.
    task automatic drain();
        logic [W-1:0] e;
        int budget;
        while (exp_q.size() > 0) begin
            budget = 0;
            while (!bus.valid && budget < 10) begin
                step();
                budget++;
            end
            if (!bus.valid) begin
                chk("drain_timeout", 32'(bus.valid), 32'd1);
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            chk("drain_code", 32'(bus.out), 32'(e));
            rr = e + W'(1);
            step();
            chk("drain_bubble", 32'(bus.valid), 32'd0);
        end
    endtask

    initial begin
        bus.req = '0;
        bus.en  = 1'b0;
        bus.ack = 1'b0;

        // reset state
        #12;
        chk("rst_valid",   32'(bus.valid),   32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_out",     32'(bus.out),     32'd0);
        chk("rst_lost",    32'(bus.lost),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b1;
        step();

        // single request, latency and clear on ack
        bus.req = 8'h20;
        step();
        chk("t2_pend", 32'(bus.pending), 32'h20);
        chk("t2_v0",   32'(bus.valid),   32'd0);
        bus.req = '0;
        step();
        chk("t2_valid", 32'(bus.valid), 32'd1);
        chk("t2_out",   32'(bus.out),   32'd5);
        bus.ack = 1'b1;
        step();
        rr = 3'd6;
        chk("t2_ackv", 32'(bus.valid),   32'd0);
        chk("t2_ackp", 32'(bus.pending), 32'd0);
        bus.ack = 1'b0;

        // en hold-off and ignored ack
        bus.en  = 1'b0;
        bus.req = 8'h10;
        step();
        bus.req = '0;
        step();
        chk("t6_pend", 32'(bus.pending), 32'h10);
        chk("t6_v0",   32'(bus.valid),   32'd0);
        bus.ack = 1'b1;
        step();
        chk("t6_ackv", 32'(bus.valid),   32'd0);
        chk("t6_ackp", 32'(bus.pending), 32'h10);
        bus.ack = 1'b0;
        bus.en  = 1'b1;
        step();
        chk("t6_valid", 32'(bus.valid), 32'd1);
        chk("t6_out",   32'(bus.out),   32'd4);
        bus.ack = 1'b1;
        step();
        rr = 3'd5;
        chk("t6_clr", 32'(bus.pending), 32'd0);
        bus.ack = 1'b0;

        // lost pulse and re-request during ack
        bus.req = 8'h08;
        step();
        bus.req = '0;
        step();
        chk("t5_out", 32'(bus.out), 32'd3);
        bus.req = 8'h08;
        step();
        chk("t5_lost1", 32'(bus.lost), 32'd1);
        bus.req = '0;
        step();
        chk("t5_lost0", 32'(bus.lost), 32'd0);
        bus.req = 8'h08;
        bus.ack = 1'b1;
        step();
        rr = 3'd4;
        chk("t5_keep", 32'(bus.pending), 32'h08);
        chk("t5_nolost", 32'(bus.lost), 32'd0);
        chk("t5_v0", 32'(bus.valid), 32'd0);
        bus.req = '0;
        bus.ack = 1'b0;
        step();
        chk("t5_rev", 32'(bus.valid), 32'd1);
        chk("t5_reo", 32'(bus.out),   32'd3);
        bus.ack = 1'b1;
        step();
        rr = 3'd4;
        chk("t5_clr", 32'(bus.pending), 32'd0);

        // multiple pending, ack held
        push_served(8'h85);
        bus.req = 8'h85;
        step();
        bus.req = '0;
        drain();
        chk("t3_empty", 32'(bus.pending), 32'd0);

        // all requests held: round-robin visits every code then wraps; fixed keeps code 0
        for (int i = 0; i < N + 1; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_q.push_back(rr + W'(i));
`else
            exp_q.push_back('0);
`endif
        end
        bus.req = 8'hFF;
        step();
        drain();

        // reset mid-PRESENT
        bus.ack = 1'b0;
        bus.req = '0;
        step();
        step();
        chk("t1_pre", 32'(bus.valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_valid", 32'(bus.valid),   32'd0);
        chk("t1_pend",  32'(bus.pending), 32'd0);
        chk("t1_out",   32'(bus.out),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_quiet", 32'(bus.valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
